// File: rtl/vedic_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : vedic_mac_acc
// Description : Accumulation stage behind the 8x8 Vedic multiplier. Sums a
//               programmed number of PW-bit products (valid/ready in) into an
//               AW-bit accumulator and presents the sum on a valid/ready
//               output handshake. Carry out of the accumulator sets a sticky
//               ovf flag.
//               Optional macro VEDIC_MAC_SAT_EN: saturating accumulate
//               (clamp to 2^AW-1) instead of modulo-2^AW wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module vedic_mac_acc #(
    parameter int PW    = 16,
    parameter int AW    = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             p_valid,
    input  logic [PW-1:0]    p_data,
    output logic             p_ready,
    output logic             acc_valid,
    output logic [AW-1:0]    acc_out,
    input  logic             acc_ready,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    c_acc_max = {AW{1'b1}};

    state_t           r_state;
    logic [AW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    // One extra bit captures the carry out of the accumulator MSB.
    logic [AW:0]      w_sum;
    logic             w_carry;
    logic [AW-1:0]    w_acc_next;

    // Extended-width add of the running sum and the zero-extended product.
    always_comb begin
        w_sum   = {1'b0, r_acc} + {{(AW + 1 - PW){1'b0}}, p_data};
        w_carry = w_sum[AW];
`ifdef VEDIC_MAC_SAT_EN
        // Once clamped, every further non-zero add carries again, so the
        // accumulator stays pinned at full scale for the rest of the run.
        w_acc_next = w_carry ? c_acc_max : w_sum[AW-1:0];
`else
        w_acc_next = w_sum[AW-1:0];
`endif
    end

    // Run control FSM together with accumulator, length counter and ovf flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                        if (len == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= len;
                            r_state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    // p_ready is constant 1 here, so p_valid alone is a transfer.
                    if (p_valid) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt - c_cnt_one;
                        if (w_carry) begin
                            r_ovf <= 1'b1;
                        end
                        if (r_cnt == c_cnt_one) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (acc_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode from the state register only.
    assign p_ready   = (r_state == S_ACC);
    assign acc_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign acc_out   = r_acc;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_vedic_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_vedic_mac_acc
// Description : Self-checking bench for vedic_mac_acc (AW=17 so the overflow
//               case is reachable). Expected sums/ovf are modelled when a run
//               is driven and queued; a monitor pops and compares them on the
//               result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vedic_mac_acc;

    localparam int PW    = 16;
    localparam int AW    = 17;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             p_valid;
    logic [PW-1:0]    p_data;
    logic             p_ready;
    logic             acc_valid;
    logic [AW-1:0]    acc_out;
    logic             acc_ready;
    logic             busy;
    logic             ovf;

    int n_chk  = 0;
    int n_pass = 0;

    logic [AW:0]   sb_q [$];   // {ovf, acc}
    logic [PW-1:0] prods [$];

    vedic_mac_acc #(.PW(PW), .AW(AW), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .p_valid   (p_valid),
        .p_data    (p_data),
        .p_ready   (p_ready),
        .acc_valid (acc_valid),
        .acc_out   (acc_out),
        .acc_ready (acc_ready),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard monitor: compare the result on every output handshake.
    always @(negedge clk) begin
        if (!rst && acc_valid && acc_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [AW:0] e;
                e = sb_q.pop_front();
                chk("sb_acc_out", 32'(acc_out), 32'(e[AW-1:0]));
                chk("sb_ovf", 32'(ovf), 32'(e[AW]));
            end
        end
    end

    // Drive one run from the products in prods. gap inserts an idle p_valid
    // cycle between products, hold keeps acc_ready low in DONE, poke asserts
    // a second start (len=9) during ACC.
    task automatic do_run(input int n, input bit gap, input int hold, input bit poke);
        longint unsigned m_acc;
        bit              m_ovf;
        m_acc = 0;
        m_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            m_acc = m_acc + longint'(prods[i]);
            if (m_acc >= (64'd1 << AW)) begin
                m_ovf = 1'b1;
`ifdef VEDIC_MAC_SAT_EN
                m_acc = (64'd1 << AW) - 1;
`else
                m_acc = m_acc - (64'd1 << AW);
`endif
            end
        end
        sb_q.push_back({m_ovf, m_acc[AW-1:0]});

        @(posedge clk); #1;
        start = 1'b1;
        len   = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        len   = '0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("p_ready_after_start", 32'(p_ready), 32'(n != 0));
        chk("acc_valid_after_start", 32'(acc_valid), 32'(n == 0));

        for (int i = 0; i < n; i++) begin
            p_valid = 1'b1;
            p_data  = prods[i];
            if (poke && i == 0) begin
                start = 1'b1;
                len   = 8'd9;
            end
            @(negedge clk);
            chk("p_ready_in_acc", 32'(p_ready), 32'd1);
            @(posedge clk); #1;
            p_valid = 1'b0;
            p_data  = '0;
            start   = 1'b0;
            len     = '0;
            if (i < n - 1) begin
                chk("acc_valid_early", 32'(acc_valid), 32'd0);
                if (gap) begin
                    @(negedge clk);
                    chk("stall_busy", 32'(busy), 32'd1);
                    chk("stall_acc_valid", 32'(acc_valid), 32'd0);
                    @(posedge clk); #1;
                end
            end
        end
        chk("acc_valid_latency", 32'(acc_valid), 32'd1);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_acc_valid", 32'(acc_valid), 32'd1);
            chk("hold_acc_out", 32'(acc_out), 32'(m_acc[AW-1:0]));
            chk("hold_p_ready", 32'(p_ready), 32'd0);
            @(posedge clk); #1;
        end

        // A start in the same cycle as acc_ready must be ignored.
        acc_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd5;
        @(posedge clk); #1;
        acc_ready = 1'b0;
        start     = 1'b0;
        len       = '0;
        chk("idle_after_ready_busy", 32'(busy), 32'd0);
        chk("idle_after_ready_valid", 32'(acc_valid), 32'd0);
        prods.delete();
    endtask

    initial begin
        #200000;
        chk("timeout", 32'd0, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        p_valid   = 1'b0;
        p_data    = '0;
        acc_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_p_ready", 32'(p_ready), 32'd0);
        chk("rst_acc_valid", 32'(acc_valid), 32'd0);
        chk("rst_acc_out", 32'(acc_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Basic run
        prods = '{16'd100, 16'd200, 16'd300, 16'd400};
        do_run(4, 1'b0, 0, 1'b0);

        // Stalls and backpressure
        prods = '{16'd5, 16'd7, 16'd9};
        do_run(3, 1'b1, 5, 1'b0);

        // Zero length
        do_run(0, 1'b0, 2, 1'b0);

        // Overflow
        prods = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        do_run(3, 1'b0, 1, 1'b0);

        // Start while busy
        prods = '{16'd1234, 16'd4321};
        do_run(2, 1'b0, 0, 1'b1);

        // Random-ish mix with stalls
        for (int i = 0; i < 6; i++) begin
            prods.push_back(PW'($urandom_range(0, 65535)));
        end
        do_run(6, 1'b1, 1, 1'b0);

        // Reset mid-run after 2 of 4 transfers
        @(posedge clk); #1;
        start = 1'b1;
        len   = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        len   = '0;
        for (int i = 0; i < 2; i++) begin
            p_valid = 1'b1;
            p_data  = 16'd1000;
            @(posedge clk); #1;
        end
        p_valid = 1'b0;
        chk("pre_rst_acc_out", 32'(acc_out), 32'd2000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_p_ready", 32'(p_ready), 32'd0);
        chk("midrst_acc_valid", 32'(acc_valid), 32'd0);
        chk("midrst_acc_out", 32'(acc_out), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);

        prods = '{16'd42};
        do_run(1, 1'b0, 1, 1'b0);

        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
